// File: rtl/clk_gen_multi.sv
// Multi-channel clock/strobe generator. Each channel divides clk by a
// runtime-programmable divisor and drives either a 50% square wave or a
// one-cycle strobe. New settings are staged in a shadow register and take
// effect only on a period boundary, so a running output never produces a
// shortened pulse. A global sync_start restarts every channel in phase.
module clk_gen_multi #(
  parameter int                    CH_COUNT  = 3,
  parameter int                    CH_SEL_W  = 2,
  parameter int                    CNT_W     = 17,
  parameter int                    DIV_RESET = 250,
  parameter logic [CH_COUNT-1:0]   EN_RESET  = {CH_COUNT{1'b1}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_start,
  input  logic                 cfg_we,
  input  logic [CH_SEL_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]     cfg_div,
  input  logic                 cfg_en,
  input  logic                 cfg_mode,
  output logic [CH_COUNT-1:0]  clk_out,
  output logic [CH_COUNT-1:0]  tick,
  output logic [CH_COUNT-1:0]  cfg_pending
);

  // Active configuration and running state
  logic [CNT_W-1:0]    cnt  [CH_COUNT];
  logic [CNT_W-1:0]    div  [CH_COUNT];
  logic [CH_COUNT-1:0] en;
  logic [CH_COUNT-1:0] mode;
  logic [CH_COUNT-1:0] sq;

  // Shadow configuration waiting for a period boundary
  logic [CNT_W-1:0]    sdiv [CH_COUNT];
  logic [CH_COUNT-1:0] sen;
  logic [CH_COUNT-1:0] smode;

  // Next-state values
  logic [CNT_W-1:0]    cnt_n  [CH_COUNT];
  logic [CNT_W-1:0]    div_n  [CH_COUNT];
  logic [CNT_W-1:0]    sdiv_n [CH_COUNT];
  logic [CH_COUNT-1:0] en_n;
  logic [CH_COUNT-1:0] mode_n;
  logic [CH_COUNT-1:0] sq_n;
  logic [CH_COUNT-1:0] tick_n;
  logic [CH_COUNT-1:0] clk_n;
  logic [CH_COUNT-1:0] pend_n;
  logic [CH_COUNT-1:0] sen_n;
  logic [CH_COUNT-1:0] smode_n;

  // Per-channel counting, shadow hand-over and output selection
  always_comb begin
    logic wr;
    logic running;
    logic term;
    logic apply;
    for (int i = 0; i < CH_COUNT; i++) begin
      cnt_n[i]   = cnt[i];
      div_n[i]   = div[i];
      sdiv_n[i]  = sdiv[i];
      en_n[i]    = en[i];
      mode_n[i]  = mode[i];
      sq_n[i]    = sq[i];
      tick_n[i]  = 1'b0;
      pend_n[i]  = cfg_pending[i];
      sen_n[i]   = sen[i];
      smode_n[i] = smode[i];

      // Writes addressed past the last channel match no index and are dropped
      wr      = cfg_we && (cfg_ch == CH_SEL_W'(i));
      running = en[i] && (div[i] != '0);
      term    = running && (cnt[i] == div[i] - 1'b1);

      // A stopped channel has no boundary to wait for; sync forces hand-over
      if (sync_start)
        apply = cfg_pending[i] || wr;
      else
        apply = cfg_pending[i] && (term || !running);

      // Counter/square state evolves under the configuration of the
      // period that is ending; the new settings start with the next one
      if (sync_start) begin
        cnt_n[i] = '0;
        sq_n[i]  = 1'b0;
      end else if (!en[i]) begin
        cnt_n[i] = '0;
        sq_n[i]  = 1'b0;
      end else if (div[i] == '0) begin
        cnt_n[i] = '0;
      end else if (term) begin
        cnt_n[i]  = '0;
        tick_n[i] = 1'b1;
        sq_n[i]   = ~sq[i];
      end else begin
        cnt_n[i] = cnt[i] + 1'b1;
      end

      // A write landing together with sync bypasses the shadow
      if (apply) begin
        if (sync_start && wr) begin
          div_n[i]  = cfg_div;
          en_n[i]   = cfg_en;
          mode_n[i] = cfg_mode;
        end else begin
          div_n[i]  = sdiv[i];
          en_n[i]   = sen[i];
          mode_n[i] = smode[i];
        end
      end

      // The old shadow is consumed before a same-cycle write replaces it
      if (wr) begin
        sdiv_n[i]  = cfg_div;
        sen_n[i]   = cfg_en;
        smode_n[i] = cfg_mode;
      end

      if (sync_start)
        pend_n[i] = 1'b0;
      else if (wr)
        pend_n[i] = 1'b1;
      else if (apply)
        pend_n[i] = 1'b0;

      clk_n[i] = mode_n[i] ? tick_n[i] : sq_n[i];
    end
  end

  // State and output registers; reset restores the power-up configuration
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_COUNT; i++) begin
      if (rst) begin
        cnt[i]         <= '0;
        div[i]         <= CNT_W'(DIV_RESET);
        en[i]          <= EN_RESET[i];
        mode[i]        <= 1'b0;
        sq[i]          <= 1'b0;
        tick[i]        <= 1'b0;
        clk_out[i]     <= 1'b0;
        cfg_pending[i] <= 1'b0;
      end else begin
        cnt[i]         <= cnt_n[i];
        div[i]         <= div_n[i];
        en[i]          <= en_n[i];
        mode[i]        <= mode_n[i];
        sq[i]          <= sq_n[i];
        tick[i]        <= tick_n[i];
        clk_out[i]     <= clk_n[i];
        cfg_pending[i] <= pend_n[i];
      end
    end
  end

  // Shadow contents are only meaningful while cfg_pending is set
  always_ff @(posedge clk) begin
    for (int i = 0; i < CH_COUNT; i++) begin
      sdiv[i]  <= sdiv_n[i];
      sen[i]   <= sen_n[i];
      smode[i] <= smode_n[i];
    end
  end

endmodule
